// File: rtl/serial_link_pkg.sv
// Shared definitions for the single-wire serial link: frame states, line levels, frame timing.
package serial_link_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Clocks from the first start-bit cycle to the last stop-bit cycle.
    function automatic int frame_len(input int width, input int cpb, input int par);
        return (2 + width + par) * cpb;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Latency: bit_done is combinational from the count; clear or reset returns the count to 0 next edge.
// Backpressure: none; free-running while clear is low.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic bit_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] bit_cnt;

    assign bit_done = (bit_cnt == LAST);

    // With CLKS_PER_BIT=1 the count sits at 0 and every cycle ends a bit.
    always_ff @(posedge clock) begin
        if (reset || clear || bit_done) begin
            bit_cnt <= '0;
        end else begin
            bit_cnt <= bit_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-in serial-out frame transmitter: start, data LSB first, optional even parity, stop.
// Latency: start bit appears the cycle after the handshake; frame lasts (2+DATA_WIDTH+PARITY_EN)*CLKS_PER_BIT.
// Backpressure: data_ready only in IDLE and not in reset; inputs ignored while a frame is in flight.
module serial_frame_tx
    import serial_link_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  tx_out,
    output logic                  busy
);

    localparam int IW = $clog2(DATA_WIDTH + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

    tx_state_e             state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_nxt;
    logic                  parity_bit;
    logic [IW-1:0]         bit_idx;
    logic                  bit_done;
    logic                  timer_clear;
    logic                  handshake;

    assign data_ready  = (state == IDLE) && !reset;
    assign handshake   = data_valid && data_ready;
    assign busy        = (state != IDLE);
    assign timer_clear = (state == IDLE);
    assign shift_nxt   = shift_reg >> 1;

    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clear),
        .bit_done(bit_done)
    );

    // tx_out is registered, so each transition loads the level of the bit that follows.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            tx_out     <= IDLE_LEVEL;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            bit_idx    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx_out <= IDLE_LEVEL;
                    if (handshake) begin
                        state      <= START;
                        tx_out     <= START_LEVEL;
                        shift_reg  <= data_in;
                        parity_bit <= ^data_in;
                        bit_idx    <= '0;
                    end
                end
                START: begin
                    if (bit_done) begin
                        state  <= DATA;
                        tx_out <= shift_reg[0];
                    end
                end
                DATA: begin
                    if (bit_done) begin
                        shift_reg <= shift_nxt;
                        if (bit_idx == LAST_IDX) begin
                            bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                state  <= PARITY;
                                tx_out <= parity_bit;
                            end else begin
                                state  <= STOP;
                                tx_out <= IDLE_LEVEL;
                            end
                        end else begin
                            bit_idx <= bit_idx + IW'(1);
                            tx_out  <= shift_nxt[0];
                        end
                    end
                end
                PARITY: begin
                    if (bit_done) begin
                        state  <= STOP;
                        tx_out <= IDLE_LEVEL;
                    end
                end
                STOP: begin
                    if (bit_done) begin
                        state  <= IDLE;
                        tx_out <= IDLE_LEVEL;
                    end
                end
                default: begin
                    state  <= IDLE;
                    tx_out <= IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Parallel-in, serial-out frame transmitter. Accepts one DATA_WIDTH word per valid/ready handshake.
- Shifts the word out on a single line as: start bit, data LSB first, optional even parity, stop bit.
- Each bit is held for CLKS_PER_BIT clocks.
- Sits at the sending end of the team's single-wire serial link; the matching capture/sampling side is the register/flip-flop receive path.

Parameters:
- DATA_WIDTH, 8, payload bits per frame (legal 1..16).
- CLKS_PER_BIT, 4, clocks each serial bit is held (legal >= 1).
- PARITY_EN, 1, 1 = append even-parity bit after data; 0 = no parity bit.

Ports:
- clock  input  1  single clock; all state changes on posedge.
- reset  input  1  synchronous, active-high reset, sampled on posedge clock.
- data_in  input  DATA_WIDTH  word to send; sampled only on handshake.
- data_valid  input  1  source has a word on data_in.
- data_ready  output  1  block can accept a word this cycle.
- tx_out  output  1  registered serial line; idle level 1.
- busy  output  1  frame in progress (any state other than IDLE).

Behaviour:
- Reset (posedge with reset=1): state=IDLE, tx_out=1, busy=0, bit/clock counters=0, shift register=0.
- data_ready=0 in any cycle where reset=1.
- Reset overrides every other input, including a handshake in the same cycle.
- Reset mid-frame aborts the frame: tx_out=1 on that edge, and no partial bits resume.
- States: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
- IDLE:
  - data_ready=1 (when reset=0), tx_out=1, busy=0.
  - Handshake = data_valid && data_ready at a posedge.
  - On handshake: latch data_in into shift register, compute parity = XOR of data_in, go to START.
- START: tx_out=0 for exactly CLKS_PER_BIT cycles, beginning the cycle after the handshake.
- DATA:
  - tx_out = shift_reg[0]; each bit held CLKS_PER_BIT cycles.
  - Shift right after each bit.
  - Exactly DATA_WIDTH bits, then go to PARITY or STOP.
- PARITY: tx_out = latched parity (even: total ones in data+parity is even), held CLKS_PER_BIT cycles.
- STOP: tx_out=1 for CLKS_PER_BIT cycles, then IDLE.
- Frame length: L = (2 + DATA_WIDTH + PARITY_EN) * CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle.
- Back-to-back transfers:
  - data_ready rises in the first IDLE cycle after STOP.
  - A handshake there starts the next START one cycle later.
  - Minimum inter-frame idle = 1 cycle with tx_out=1.
- data_in and data_valid changes while busy=1 are ignored. The latched word is immutable until the frame ends.
- CLKS_PER_BIT=1: every bit lasts 1 cycle; the counter never wraps past 0.
- Bit-time counter counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. Width = clog2(CLKS_PER_BIT), minimum 1.
- Bit index counter width = clog2(DATA_WIDTH+1).
- busy=1 from the first START cycle through the last STOP cycle inclusive.
- No X on any output after the first reset edge.

Decomposition:
- Shared package serial_link_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - IDLE_LEVEL=1'b1 and START_LEVEL=1'b0;
  - a frame_len(width, cpb, par) constant function, reused by the future receive side and the benches.
- One natural sub-module: bit_timer.
  - Parameterised on CLKS_PER_BIT.
  - Inputs: clock, reset, clear. Output: bit_done pulse on the last cycle of each bit.
- The FSM and shift register stay in serial_frame_tx.

Test Plan:
1. Reset held 3 cycles with data_valid=1 -> tx_out=1, busy=0, data_ready=0 throughout; data_ready=1 on the first cycle after reset drops.
2. Defaults; send 0xA5 -> line bits, 4 cycles each: 0, 1,0,1,0,0,1,0,1, parity 0, stop 1. Total 44 cycles busy=1; data_ready=0 during the frame.
3. Send 0x01, then 0x7F held valid continuously -> second frame START begins exactly 1 idle cycle after the first STOP ends. Parities are 1 and 1; 0x7F data bits are 1,1,1,1,1,1,1,0.
4. During the 0xA5 frame, change data_in to 0xFF with data_valid=1 -> transmitted bits are unchanged and no extra frame is queued.
5. Assert reset at cycle 20 of a frame -> tx_out=1 and busy=0 on that edge; the next handshake with 0x3C produces a full clean 44-cycle frame.
6. CLKS_PER_BIT=1, PARITY_EN=0, DATA_WIDTH=8; send 0x80 -> 10-cycle frame: 0, 0,0,0,0,0,0,0,1, 1.
